// File: rtl/i2s_clock_controller_if.sv
// Control/status bundle between the host logic and the I2S clock controller.
// The controller uses the master modport; the host side uses the slave modport.
interface i2s_clock_controller_if #(
   parameter int FrameCountWidth = 16
) ();

   logic                       i_START;
   logic                       i_STOP;
   logic [FrameCountWidth-1:0] i_FrameLimit;
   logic                       o_SCK;
   logic                       o_WS;
   logic                       o_ENABLE;
   logic                       o_Busy;
   logic                       o_FrameStrobe;
   logic                       o_Done;
   logic [FrameCountWidth-1:0] o_FrameCount;

   modport master (
      input  i_START,
      input  i_STOP,
      input  i_FrameLimit,
      output o_SCK,
      output o_WS,
      output o_ENABLE,
      output o_Busy,
      output o_FrameStrobe,
      output o_Done,
      output o_FrameCount
   );

   modport slave (
      output i_START,
      output i_STOP,
      output i_FrameLimit,
      input  o_SCK,
      input  o_WS,
      input  o_ENABLE,
      input  o_Busy,
      input  o_FrameStrobe,
      input  o_Done,
      input  o_FrameCount
   );

endinterface

// File: rtl/i2s_clock_controller.sv
// I2S master sequencer: divides i_CLK into SCK, generates WS, and starts/stops
// streaming only on whole stereo-frame boundaries. All outputs are registered.
module i2s_clock_controller #(
   parameter int DataWidth       = 16,
   parameter int ClockDivide     = 4,
   parameter int FrameCountWidth = 16
) (
   input  logic                      i_CLK,
   input  logic                      i_NRESET,
   i2s_clock_controller_if.master    bus
);

   localparam int DivWidth = (ClockDivide > 1) ? $clog2(ClockDivide) : 1;
   localparam int BitWidth = $clog2(2 * DataWidth);
   localparam logic [DivWidth-1:0] DivLast = DivWidth'(ClockDivide - 1);
   localparam logic [BitWidth-1:0] BitLast = BitWidth'(2 * DataWidth - 1);
   localparam logic [BitWidth-1:0] BitHalf = BitWidth'(DataWidth);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   state_t                     state_r, state_s;
   logic [DivWidth-1:0]        div_r, div_s;
   logic [BitWidth-1:0]        bit_r, bit_s, bit_next_s;
   logic                       sck_r, sck_s;
   logic                       ws_r, ws_s;
   logic                       enable_r, enable_s;
   logic                       busy_r, busy_s;
   logic                       strobe_r, strobe_s;
   logic                       done_r, done_s;
   logic [FrameCountWidth-1:0] count_r, count_s, count_inc_s;
   logic [FrameCountWidth-1:0] limit_r, limit_s;
   logic                       frame_end_s;

   // State and output registers; reset aborts any frame without a done pulse.
   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET) begin
         state_r  <= ST_IDLE;
         div_r    <= '0;
         bit_r    <= '0;
         sck_r    <= 1'b0;
         ws_r     <= 1'b0;
         enable_r <= 1'b0;
         busy_r   <= 1'b0;
         strobe_r <= 1'b0;
         done_r   <= 1'b0;
         count_r  <= '0;
         limit_r  <= '0;
      end else begin
         state_r  <= state_s;
         div_r    <= div_s;
         bit_r    <= bit_s;
         sck_r    <= sck_s;
         ws_r     <= ws_s;
         enable_r <= enable_s;
         busy_r   <= busy_s;
         strobe_r <= strobe_s;
         done_r   <= done_s;
         count_r  <= count_s;
         limit_r  <= limit_s;
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_s     = state_r;
      div_s       = div_r;
      bit_s       = bit_r;
      sck_s       = sck_r;
      ws_s        = ws_r;
      enable_s    = enable_r;
      busy_s      = busy_r;
      strobe_s    = 1'b0;
      done_s      = 1'b0;
      count_s     = count_r;
      limit_s     = limit_r;
      frame_end_s = 1'b0;
      bit_next_s  = (bit_r == BitLast) ? '0 : bit_r + BitWidth'(1);
      count_inc_s = count_r + FrameCountWidth'(1);

      case (state_r)
         ST_IDLE: begin
            sck_s    = 1'b0;
            ws_s     = 1'b0;
            enable_s = 1'b0;
            busy_s   = 1'b0;
            div_s    = '0;
            bit_s    = '0;
            // A simultaneous stop request is meaningless here, so start wins.
            if (bus.i_START) begin
               state_s  = ST_RUN;
               enable_s = 1'b1;
               busy_s   = 1'b1;
               count_s  = '0;
               limit_s  = bus.i_FrameLimit;
            end else begin
               state_s  = ST_IDLE;
            end
         end

         ST_RUN, ST_STOPPING: begin
            if (div_r == DivLast) begin
               div_s = '0;
               sck_s = ~sck_r;
               // WS and the bit counter move on the SCK fall so WS is stable at each rise.
               if (sck_r) begin
                  bit_s       = bit_next_s;
                  ws_s        = (bit_next_s >= BitHalf);
                  frame_end_s = (bit_next_s == '0);
               end else begin
                  bit_s       = bit_r;
               end
            end else begin
               div_s = div_r + DivWidth'(1);
            end

            if (frame_end_s) begin
               strobe_s = 1'b1;
               count_s  = count_inc_s;
            end else begin
               count_s  = count_r;
            end

            if (frame_end_s && ((state_r == ST_STOPPING) ||
                                ((limit_r != '0) && (count_inc_s == limit_r)))) begin
               state_s  = ST_IDLE;
               enable_s = 1'b0;
               busy_s   = 1'b0;
               sck_s    = 1'b0;
               ws_s     = 1'b0;
               done_s   = 1'b1;
               div_s    = '0;
               bit_s    = '0;
            end else if ((state_r == ST_RUN) && bus.i_STOP) begin
               state_s  = ST_STOPPING;
            end else begin
               state_s  = state_r;
            end
         end

         default: begin
            state_s  = ST_IDLE;
            div_s    = '0;
            bit_s    = '0;
            sck_s    = 1'b0;
            ws_s     = 1'b0;
            enable_s = 1'b0;
            busy_s   = 1'b0;
            count_s  = '0;
            limit_s  = '0;
         end
      endcase
   end

   assign bus.o_SCK         = sck_r;
   assign bus.o_WS          = ws_r;
   assign bus.o_ENABLE      = enable_r;
   assign bus.o_Busy        = busy_r;
   assign bus.o_FrameStrobe = strobe_r;
   assign bus.o_Done        = done_r;
   assign bus.o_FrameCount  = count_r;

endmodule

// File: tb/tb_i2s_clock_controller.sv
// Directed bench for i2s_clock_controller with DataWidth=4, ClockDivide=2:
// SCK period 4 clocks, 16 clocks per slot, 32 clocks per frame.
module tb_i2s_clock_controller;

   localparam int DW         = 4;
   localparam int CD         = 2;
   localparam int FCW        = 8;
   localparam int SCK_PERIOD = 4;
   localparam int SLOT       = 16;
   localparam int FRAME      = 32;
   localparam int NEVER      = 100000;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   i2s_clock_controller_if #(.FrameCountWidth(FCW)) bus ();

   i2s_clock_controller #(
      .DataWidth       (DW),
      .ClockDivide     (CD),
      .FrameCountWidth (FCW)
   ) dut (
      .i_CLK    (clk),
      .i_NRESET (rst_n),
      .bus      (bus.master)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed vector: {count[7:0], sck, ws, strobe, enable, busy, done}.
   function automatic logic [31:0] obs_vec();
      return {18'd0, bus.o_FrameCount, bus.o_SCK, bus.o_WS, bus.o_FrameStrobe,
              bus.o_ENABLE, bus.o_Busy, bus.o_Done};
   endfunction

   // Expected vector k clocks after the start edge, with the run ending at k_end.
   function automatic logic [31:0] exp_vec(input int k, input int k_end);
      logic       sck, ws, stb, en, busy, done;
      logic [7:0] cnt;
      if (k < k_end) begin
         sck  = ((k % SCK_PERIOD) >= (SCK_PERIOD / 2));
         ws   = ((k % FRAME) >= SLOT);
         stb  = ((k % FRAME) == 0);
         en   = 1'b1;
         busy = 1'b1;
         done = 1'b0;
         cnt  = 8'(k / FRAME);
      end else if (k == k_end) begin
         sck  = 1'b0;
         ws   = 1'b0;
         stb  = 1'b1;
         en   = 1'b0;
         busy = 1'b0;
         done = 1'b1;
         cnt  = 8'(k_end / FRAME);
      end else begin
         sck  = 1'b0;
         ws   = 1'b0;
         stb  = 1'b0;
         en   = 1'b0;
         busy = 1'b0;
         done = 1'b0;
         cnt  = 8'(k_end / FRAME);
      end
      return {18'd0, cnt, sck, ws, stb, en, busy, done};
   endfunction

   task automatic start_run(input logic [FCW-1:0] limit, input logic stop_too);
      bus.i_FrameLimit = limit;
      bus.i_START      = 1'b1;
      bus.i_STOP       = stop_too;
      step();
      bus.i_START      = 1'b0;
      bus.i_STOP       = 1'b0;
      check("start", obs_vec(), 32'h0000_0006);
   endtask

   task automatic run_check(input string tag, input int k_total, input int k_end,
                            input int stop_k, input logic start_too);
      for (int k = 1; k <= k_total; k++) begin
         bus.i_STOP  = (k == stop_k);
         bus.i_START = start_too && (k == stop_k);
         step();
         check($sformatf("%s_k%0d", tag, k), obs_vec(), exp_vec(k, k_end));
      end
      bus.i_STOP  = 1'b0;
      bus.i_START = 1'b0;
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.i_START      = 1'b1;
      bus.i_STOP       = 1'b0;
      bus.i_FrameLimit = 8'd0;

      // Reset held with start asserted, then released with start low.
      step();
      step();
      check("rst_hold", obs_vec(), 32'h0000_0000);
      rst_n       = 1'b1;
      bus.i_START = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("rst_idle%0d", i), obs_vec(), 32'h0000_0000);
      end

      // Continuous: three full frames, then a stop at k=100 ends at frame 4.
      start_run(8'd0, 1'b0);
      run_check("cont", 131, 128, 100, 1'b0);

      // Frame limit 3: done and enable fall on the third strobe.
      start_run(8'd3, 1'b0);
      run_check("lim3", 100, 96, 0, 1'b0);

      // Stop 10 clocks into frame 2: ends at the close of frame 2.
      start_run(8'd0, 1'b0);
      run_check("stop", 67, 64, 42, 1'b0);

      // Start+stop in IDLE starts; start+stop in RUN stops.
      start_run(8'd0, 1'b1);
      run_check("both", 67, 64, 40, 1'b1);

      // Reset during the right slot aborts immediately with no done pulse.
      start_run(8'd0, 1'b0);
      run_check("pre_rst", 20, NEVER, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_async", obs_vec(), 32'h0000_0000);
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("rst_mid%0d", i), obs_vec(), 32'h0000_0000);
      end
      rst_n = 1'b1;
      step();
      check("rst_rel", obs_vec(), 32'h0000_0000);
      start_run(8'd0, 1'b0);
      run_check("post_rst", 40, NEVER, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
